conv_mem_responder: RTL and testbench
=====================================

# conv_mem_responder

Synthesizable memory-side responder for the CONV accelerator interface. It holds the input image and the five layer result banks, drives the `ready`/`busy` start handshake, answers `iaddr` image fetches and `crd`/`cwr`/`csel` bank accesses, and exposes a host-side pixel load port and a result readback port. It sits between the host/DMA and CONV as the data-owning end of the CONV memory protocol.

## Interface
- `DW`, 20: pixel/result data width.
- `IMG_AW`, 12: image address width (image holds 2^IMG_AW pixels).
- `L0_AW`, 12: address width of banks 001 and 010.
- `L1_AW`, 10: address width of banks 011 and 100.
- `L2_AW`, 11: address width of bank 101.
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `pix_valid`  in  1  host image-pixel write strobe.
- `pix_data`  in  DW  host pixel value.
- `pix_ready`  out  1  image load accepted this cycle.
- `ready`  out  1  start request to CONV.
- `busy`  in  1  CONV busy.
- `iaddr`  in  12  image fetch address.
- `idata`  out  DW  image data.
- `cwr`  in  1  bank write strobe.
- `caddr_wr`  in  12  bank write address.
- `cdata_wr`  in  DW  bank write data.
- `crd`  in  1  bank read strobe.
- `caddr_rd`  in  12  bank read address.
- `cdata_rd`  out  DW  bank read data.
- `csel`  in  3  bank select.
- `done`  out  1  one-cycle pulse at end of run.
- `rb_en`  in  1  host readback strobe.
- `rb_sel`  in  3  readback bank (same encoding as `csel`).
- `rb_addr`  in  12  readback address.
- `rb_data`  out  DW  readback data.

## Operation
- States: LOAD, ARM, RUN, DONE. Reset enters LOAD, load pointer `wptr`=0.
- LOAD: `pix_ready`=1. Each cycle with `pix_valid`=1 writes `pix_data` to IMG[`wptr`], `wptr`++. The write to address 2^IMG_AW−1 moves to ARM next cycle; `wptr` wraps to 0.
- ARM: `ready`=1. When `busy` is sampled 1, go to RUN; `ready` is 0 from the following cycle.
- RUN: serve CONV. When `busy` is sampled 0, go to DONE.
- DONE: `done`=1 for exactly one cycle, then LOAD. Bank and image contents are retained.
- Bank map: `csel` 001→L0_0, 010→L0_1, 011→L1_0, 100→L1_1, 101→L2. 000/110/111: writes discarded, reads leave `cdata_rd` unchanged.
- Addresses are truncated to the selected bank/image width (upper bits ignored, no error).
- Image fetch and bank access are honoured in every state; the protocol is defined only in RUN.
- `pix_valid` outside LOAD is ignored; `pix_ready`=0 there.
- Readback: `rb_en` in LOAD, ARM or DONE loads `rb_data` from the selected bank. In RUN, `rb_en` is ignored and `rb_data` holds its value.
- Same-cycle `cwr` and `crd` to the same bank and address return the old data (read-before-write).
- Reset mid-operation: state→LOAD, `wptr`=0, all outputs go to reset values. Memory arrays are not cleared.

## Timing
- Reset values: `ready`=0, `done`=0, `pix_ready`=0 while `reset`=0 (1 after release in LOAD), `idata`=0, `cdata_rd`=0, `rb_data`=0.
- `idata` is registered, IMG[`iaddr`] sampled at edge N and valid after edge N. It updates every cycle, giving one-cycle fetch latency.
- `cdata_rd` is registered. It loads at edge N when `crd`=1 and holds otherwise.
- Bank write takes effect at the edge where `cwr`=1, so a read issued the next cycle sees the new data.
- `rb_data`: one-cycle latency, same as `cdata_rd`.
- LOAD→ARM occurs one edge after the last pixel write. `ready` rises in that cycle.

## Test plan
- Load ramp IMG[i]=i (IMG_AW=4, 16 pixels) → `ready` rises the cycle after the 16th write. A 17th `pix_valid` is ignored with `pix_ready`=0.
- Raise `busy` in ARM → `ready` low the next cycle. Sweep `iaddr`=0..15 → `idata`=0..15, each one cycle late.
- In RUN, write 20'hABCDE to csel 011 addr 5, then read it the next cycle → `cdata_rd`=20'hABCDE. csel 110 write/read → no change anywhere.
- Same-cycle `cwr`(20'h12345)/`crd` to csel 001 addr 7, holding 20'h00001 → `cdata_rd`=20'h00001. A following read returns 20'h12345.
- Drop `busy` → `done` high exactly one cycle, state LOAD. `rb_en` on csel 101 addr 3 (written 20'h0F0F0) → `rb_data`=20'h0F0F0; `rb_en` during RUN → `rb_data` unchanged.
- Assert `reset`=0 mid-RUN → `ready`/`done`/`idata`/`cdata_rd`=0 immediately. After release, `pix_ready`=1, `wptr`=0, and previously written bank data is still readable.

Source files
------------

// File: rtl/conv_mem_responder.sv
// Data-owning end of the CONV memory protocol: image store, five result banks,
// start handshake toward CONV, host pixel-load port and host result readback.
module conv_mem_responder #(
  parameter int DW     = 20,
  parameter int IMG_AW = 12,
  parameter int L0_AW  = 12,
  parameter int L1_AW  = 10,
  parameter int L2_AW  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [11:0]   iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [11:0]   caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [11:0]   caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  input  logic          rb_en,
  input  logic [2:0]    rb_sel,
  input  logic [11:0]   rb_addr,
  output logic [DW-1:0] rb_data,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] SEL_L0_0 = 3'b001;
  localparam logic [2:0] SEL_L0_1 = 3'b010;
  localparam logic [2:0] SEL_L1_0 = 3'b011;
  localparam logic [2:0] SEL_L1_1 = 3'b100;
  localparam logic [2:0] SEL_L2   = 3'b101;

  state_t            state_q, state_d;
  logic [IMG_AW-1:0] wptr_q;
  logic              load_fire;

  logic [DW-1:0] img      [(1 << IMG_AW)];
  logic [DW-1:0] mem_l0_0 [(1 << L0_AW)];
  logic [DW-1:0] mem_l0_1 [(1 << L0_AW)];
  logic [DW-1:0] mem_l1_0 [(1 << L1_AW)];
  logic [DW-1:0] mem_l1_1 [(1 << L1_AW)];
  logic [DW-1:0] mem_l2   [(1 << L2_AW)];

  logic          cr_hit, rb_hit;
  logic [DW-1:0] cr_val, rb_val;

  // Handshakes: a pixel transfers on any edge where pix_valid && pix_ready;
  // ready stays high until busy is sampled high; done is a single-cycle pulse.
  assign load_fire = pix_valid && pix_ready;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_fire) wptr_q <= wptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_LOAD: begin
        pix_ready = reset;
        if (load_fire && (&wptr_q)) state_d = S_ARM;
      end
      S_ARM: begin
        ready = 1'b1;
        if (busy) state_d = S_RUN;
      end
      S_RUN: begin
        if (!busy) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Memory arrays carry no reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (load_fire) img[wptr_q] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (cwr) begin
      case (csel)
        SEL_L0_0: mem_l0_0[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        SEL_L0_1: mem_l0_1[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        SEL_L1_0: mem_l1_0[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        SEL_L1_1: mem_l1_1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        SEL_L2:   mem_l2[caddr_wr[L2_AW-1:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end

  always_comb begin
    cr_hit = 1'b1;
    cr_val = '0;
    case (csel)
      SEL_L0_0: cr_val = mem_l0_0[caddr_rd[L0_AW-1:0]];
      SEL_L0_1: cr_val = mem_l0_1[caddr_rd[L0_AW-1:0]];
      SEL_L1_0: cr_val = mem_l1_0[caddr_rd[L1_AW-1:0]];
      SEL_L1_1: cr_val = mem_l1_1[caddr_rd[L1_AW-1:0]];
      SEL_L2:   cr_val = mem_l2[caddr_rd[L2_AW-1:0]];
      default:  cr_hit = 1'b0;
    endcase
  end

  always_comb begin
    rb_hit = 1'b1;
    rb_val = '0;
    case (rb_sel)
      SEL_L0_0: rb_val = mem_l0_0[rb_addr[L0_AW-1:0]];
      SEL_L0_1: rb_val = mem_l0_1[rb_addr[L0_AW-1:0]];
      SEL_L1_0: rb_val = mem_l1_0[rb_addr[L1_AW-1:0]];
      SEL_L1_1: rb_val = mem_l1_1[rb_addr[L1_AW-1:0]];
      SEL_L2:   rb_val = mem_l2[rb_addr[L2_AW-1:0]];
      default:  rb_hit = 1'b0;
    endcase
  end

  // Reads sample the arrays before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idata    <= '0;
      cdata_rd <= '0;
      rb_data  <= '0;
    end else begin
      idata <= img[iaddr[IMG_AW-1:0]];
      if (crd && cr_hit) cdata_rd <= cr_val;
      if (rb_en && rb_hit && (state_q != S_RUN)) rb_data <= rb_val;
    end
  end

  generate
    if (IMG_AW < 12) begin : g_img_trunc
      logic unused_iaddr_hi;
      assign unused_iaddr_hi = &{1'b0, iaddr[11:IMG_AW]};
    end
    if (L1_AW < 12) begin : g_l1_trunc
      logic unused_l1_hi;
      assign unused_l1_hi = &{1'b0, caddr_wr[11:L1_AW], caddr_rd[11:L1_AW], rb_addr[11:L1_AW]};
    end
  endgenerate

endmodule

// File: tb/tb_conv_mem_responder.sv
// Bench for conv_mem_responder with a 16-pixel image: load, handshake, fetch,
// bank access, readback and mid-run reset, checked against an expected queue.
module tb_conv_mem_responder;

  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          ready;
  logic          busy;
  logic [11:0]   iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [11:0]   caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [11:0]   caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          done;
  logic          rb_en;
  logic [2:0]    rb_sel;
  logic [11:0]   rb_addr;
  logic [DW-1:0] rb_data;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  conv_mem_responder #(.DW(DW), .IMG_AW(4)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .done(done),
    .rb_en(rb_en), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = 32'hxxxx_xxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input int base);
    for (int i = 0; i < 16; i++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(base + i);
      check("pix_ready_load", pix_ready, 1);
      step();
    end
    pix_valid = 1'b0;
  endtask

  task automatic bank_write(input logic [2:0] sel, input logic [11:0] a, input logic [DW-1:0] d);
    cwr = 1'b1; csel = sel; caddr_wr = a; cdata_wr = d;
    step();
    cwr = 1'b0;
  endtask

  task automatic bank_read(input string tag, input logic [2:0] sel, input logic [11:0] a,
                           input logic [DW-1:0] e);
    crd = 1'b1; csel = sel; caddr_rd = a;
    exp_q.push_back(32'(e));
    step();
    crd = 1'b0;
    sb_pop(tag, 32'(cdata_rd));
  endtask

  initial begin
    int a;
    reset = 1'b0; pix_valid = 1'b0; pix_data = '0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
    csel = 3'b000; rb_en = 1'b0; rb_sel = 3'b000; rb_addr = '0;

    repeat (3) step();
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_idata", idata, 0);
    check("rst_cdata_rd", cdata_rd, 0);
    check("rst_rb_data", rb_data, 0);
    check("rst_state", state_dbg, ST_LOAD);
    reset = 1'b1;
    #1;
    check("rel_pix_ready", pix_ready, 1);

    // ramp load; ARM follows the 16th write, a 17th pixel is refused
    load_image(0);
    check("arm_ready", ready, 1);
    check("arm_state", state_dbg, ST_ARM);
    check("arm_pix_ready", pix_ready, 0);
    pix_valid = 1'b1; pix_data = 20'd99;
    step();
    pix_valid = 1'b0;
    check("arm_hold_ready", ready, 1);

    busy = 1'b1;
    step();
    check("run_ready_low", ready, 0);
    check("run_state", state_dbg, ST_RUN);

    // image fetch sweep, one cycle late
    for (int k = 0; k < 16; k++) begin
      iaddr = 12'(k);
      exp_q.push_back(32'(k));
      step();
      sb_pop("idata_sweep", 32'(idata));
    end
    // random fetches with junk in the ignored upper address bits
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(0, 15);
      iaddr = {8'($urandom_range(0, 255)), 4'(a)};
      exp_q.push_back(32'(a));
      step();
      sb_pop("idata_trunc", 32'(idata));
    end

    bank_write(3'b011, 12'd5, 20'hABCDE);
    bank_read("l1_0_rd", 3'b011, 12'd5, 20'hABCDE);
    bank_write(3'b110, 12'd5, 20'h11111);
    bank_read("sel110_hold", 3'b110, 12'd5, 20'hABCDE);
    bank_read("l1_0_intact", 3'b011, 12'd5, 20'hABCDE);
    bank_write(3'b100, 12'hC05, 20'h22222);
    bank_read("l1_1_trunc", 3'b100, 12'h005, 20'h22222);

    // same-cycle write and read: old data returned
    bank_write(3'b001, 12'd7, 20'h00001);
    cwr = 1'b1; cdata_wr = 20'h12345; caddr_wr = 12'd7;
    bank_read("rbw_old", 3'b001, 12'd7, 20'h00001);
    bank_read("rbw_new", 3'b001, 12'd7, 20'h12345);

    bank_write(3'b101, 12'd3, 20'h0F0F0);
    rb_en = 1'b1; rb_sel = 3'b101; rb_addr = 12'd3;
    step();
    rb_en = 1'b0;
    check("rb_run_ignored", rb_data, 0);

    busy = 1'b0;
    step();
    check("done_pulse", done, 1);
    check("done_state", state_dbg, ST_DONE);
    step();
    check("done_low", done, 0);
    check("back_load", state_dbg, ST_LOAD);

    rb_en = 1'b1; rb_sel = 3'b101; rb_addr = 12'd3;
    exp_q.push_back(32'h0F0F0);
    step();
    rb_en = 1'b0;
    sb_pop("rb_load", 32'(rb_data));

    // second run, then reset in the middle of it
    load_image(100);
    busy = 1'b1;
    step();
    rb_en = 1'b1; rb_sel = 3'b011; rb_addr = 12'd5;
    iaddr = 12'd3; crd = 1'b1; csel = 3'b011; caddr_rd = 12'd5;
    step();
    rb_en = 1'b0; crd = 1'b0;
    check("run2_rb_hold", rb_data, 20'h0F0F0);
    check("run2_idata", idata, 103);
    check("run2_cdata", cdata_rd, 20'hABCDE);

    reset = 1'b0;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_idata", idata, 0);
    check("mid_rst_cdata", cdata_rd, 0);
    check("mid_rst_rb", rb_data, 0);
    check("mid_rst_pix_ready", pix_ready, 0);
    busy = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("post_rst_pix_ready", pix_ready, 1);
    check("post_rst_state", state_dbg, ST_LOAD);

    // wptr restarted at 0: first pixel lands at IMG[0]
    pix_valid = 1'b1; pix_data = 20'd777; iaddr = 12'd0;
    step();
    pix_valid = 1'b0;
    exp_q.push_back(32'd777);
    step();
    sb_pop("wptr_zero", 32'(idata));
    iaddr = 12'd1;
    exp_q.push_back(32'd101);
    step();
    sb_pop("img_retained", 32'(idata));

    bank_read("bank_retained_l1", 3'b011, 12'd5, 20'hABCDE);
    bank_read("bank_retained_l0", 3'b001, 12'd7, 20'h12345);
    rb_en = 1'b1; rb_sel = 3'b101; rb_addr = 12'd3;
    exp_q.push_back(32'h0F0F0);
    step();
    rb_en = 1'b0;
    sb_pop("rb_retained", 32'(rb_data));

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
